m_stage_dm: RTL and testbench
=============================

# m_stage_dm

Memory-stage data memory for the five-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It takes the ALU address and forwarded store data, and performs word, halfword and byte stores into an internal RAM with byte-lane merging. It returns the sign- or zero-extended load result on `M_DR`, which the MEM/WB register latches on the next edge. It also flags misaligned or out-of-range accesses.

## Interface
- `DEPTH_LOG2`, default 12: word-address width. The RAM holds 2^12 = 4096 words (16 KiB) starting at byte address 0.
- `clk`  in  1  system clock; all RAM writes occur on the rising edge.
- `reset`  in  1  asynchronous, active-low. Low clears the entire RAM to 0 immediately, independent of `clk`.
- `M_PC`  in  32  PC of the instruction in M; used only by the write log.
- `M_AO`  in  32  byte address from the ALU.
- `M_WD`  in  32  store data, already forwarded; the low bits are used for sh and sb.
- `M_MemWrite`  in  1  the instruction in M is a store.
- `M_MemRead`  in  1  the instruction in M is a load.
- `M_MemSize`  in  2  access size: 00 = word, 01 = half, 10 = byte, 11 = reserved (treated as word).
- `M_LoadSigned`  in  1  sign-extend a sub-word load when 1; zero-extend when 0.
- `M_DR`  out  32  extended load data; combinational.
- `M_AdEL`  out  1  load address error; combinational.
- `M_AdES`  out  1  store address error; combinational.

## Operation
- Word index is `M_AO[DEPTH_LOG2+1:2]`. Byte lane is `M_AO[1:0]`.
- Misaligned access:
  - word: `M_AO[1:0] != 0`
  - half: `M_AO[0] != 0`
- Out of range: `M_AO >= 4*2^DEPTH_LOG2`.
- `M_AdEL = M_MemRead & (misaligned | out of range)`.
- `M_AdES = M_MemWrite & (misaligned | out of range)`.
- Store byte enables:
  - word: 1111
  - half: 0011 when `M_AO[1]=0`, 1100 when `M_AO[1]=1`
  - byte: one-hot on `M_AO[1:0]`
- Store data is replicated into the enabled lanes: the halfword at `M_WD[15:0]` and the byte at `M_WD[7:0]`. Lanes not enabled keep their old value.
- A store with `M_AdES=1` is suppressed: no RAM change and no log line.
- Load path:
  - select the word, then the half or byte by lane, then extend per `M_LoadSigned`.
  - a word load ignores `M_LoadSigned`.
- When `M_MemRead=0` or `M_AdEL=1`, `M_DR` is 0.
- `M_MemRead` and `M_MemWrite` asserted together: the read returns pre-edge RAM contents, and the write commits at the edge.
- Reset: all RAM words are 0. `M_DR`, `M_AdEL` and `M_AdES` follow combinationally from the inputs.

## Timing
- Write latency: 1 edge. A store in cycle t is visible to a load in cycle t+1.
- Read latency: 0. `M_DR` is valid in the same cycle for MEM/WB capture at the next edge.
- `reset` asserted mid-cycle clears the RAM immediately; a write on that edge is discarded.
- On `reset` deassertion, writes resume from the first rising edge that sees `reset=1`.
- No stall or handshake; one access per cycle. A pipeline bubble drives `M_MemRead=M_MemWrite=0`.

## Configuration
- `DM_WRITE_LOG_EN` defined: every committed store prints one line, `$display("%d@%h: *%h <= %h", $time, M_PC, {M_AO[31:2],2'b00}, merged_word)`. `merged_word` is the full 32-bit word after lane merging.
- `DM_WRITE_LOG_EN` undefined: no display. Functional behaviour is identical.

## Test plan
- Reset low, then high; lw from 0x0000_0010 -> `M_DR=0`, `M_AdEL=0`.
- sw 0x1234_5678 to 0x40; next cycle lw 0x40 -> `M_DR=0x1234_5678`. With the macro defined, the log shows `*00000040 <= 12345678`.
- After the above: sb 0xAB to 0x41, then lb 0x41 -> `0xFFFF_FFAB`; lbu 0x41 -> `0x0000_00AB`; lw 0x40 -> `0x1234_AB78`.
- sh 0x8001 to 0x42; lh 0x42 -> `0xFFFF_8001`; lhu 0x42 -> `0x0000_8001`; lw 0x40 -> `0x8001_AB78`.
- sw to 0x46 -> `M_AdES=1`, RAM unchanged, no log. lh at 0x43 -> `M_AdEL=1`, `M_DR=0`. lw at 0x0000_4000 -> `M_AdEL=1`.
- sw 0xFFFF_FFFF to 0x80, with `reset` pulsed low mid-cycle before the edge -> lw 0x80 after release returns 0.

Source files
------------

// File: rtl/m_stage_dm.sv
// m_stage_dm: memory-stage data memory for the five-stage MIPS pipeline.
// Word/half/byte stores merge into a word-wide RAM through byte lanes; loads
// are combinational and sign- or zero-extended. Misaligned or out-of-range
// accesses raise M_AdEL/M_AdES and never touch the RAM.
// Optional feature: define DM_WRITE_LOG_EN to print one line per committed store.
module m_stage_dm #(
   parameter int DEPTH_LOG2 = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] M_PC,
   input  logic [31:0] M_AO,
   input  logic [31:0] M_WD,
   input  logic        M_MemWrite,
   input  logic        M_MemRead,
   input  logic [1:0]  M_MemSize,
   input  logic        M_LoadSigned,
   output logic [31:0] M_DR,
   output logic        M_AdEL,
   output logic        M_AdES
);

   localparam int          WORDS      = 1 << DEPTH_LOG2;
   localparam logic [32:0] BYTE_LIMIT = 33'(4) << DEPTH_LOG2;

   logic [31:0]           mem [WORDS];
   logic [DEPTH_LOG2-1:0] wordIdx;
   logic                  isHalf;
   logic                  isByte;
   logic                  misaligned;
   logic                  outOfRange;
   logic                  addrErr;
   logic                  writeEn;
   logic [31:0]           oldWord;
   logic [3:0]            byteEn;
   logic [31:0]           storeData;
   logic [31:0]           mergedWord;
   logic [15:0]           halfSel;
   logic [7:0]            byteSel;

   assign wordIdx = M_AO[DEPTH_LOG2+1:2];
   assign isHalf  = (M_MemSize == 2'b01);
   assign isByte  = (M_MemSize == 2'b10);

   // Reserved size 2'b11 falls through to the word rules everywhere below.
   assign misaligned = isHalf ? M_AO[0] : (isByte ? 1'b0 : (M_AO[1:0] != 2'b00));
   assign outOfRange = ({1'b0, M_AO} >= BYTE_LIMIT);
   assign addrErr    = misaligned | outOfRange;
   assign M_AdEL     = M_MemRead & addrErr;
   assign M_AdES     = M_MemWrite & addrErr;
   assign writeEn    = M_MemWrite & ~addrErr;

   assign oldWord = mem[wordIdx];
   assign halfSel = M_AO[1] ? oldWord[31:16] : oldWord[15:0];
   assign byteSel = oldWord[{M_AO[1:0], 3'b000} +: 8];

   // Store lane enables and lane-replicated store data for the access size.
   always_comb begin
      byteEn    = 4'b1111;
      storeData = M_WD;
      if (isHalf) begin
         byteEn    = M_AO[1] ? 4'b1100 : 4'b0011;
         storeData = {2{M_WD[15:0]}};
      end else if (isByte) begin
         byteEn    = 4'b0001 << M_AO[1:0];
         storeData = {4{M_WD[7:0]}};
      end
   end

   // Full word after merging: enabled lanes take new data, others keep old.
   always_comb begin
      mergedWord = oldWord;
      for (int i = 0; i < 4; i++) begin
         if (byteEn[i]) begin
            mergedWord[8*i +: 8] = storeData[8*i +: 8];
         end
      end
   end

   // Load result: pick half or byte by lane and extend; zero on idle or error.
   always_comb begin
      M_DR = '0;
      if (M_MemRead && !addrErr) begin
         if (isHalf) begin
            M_DR = {{16{M_LoadSigned & halfSel[15]}}, halfSel};
         end else if (isByte) begin
            M_DR = {{24{M_LoadSigned & byteSel[7]}}, byteSel};
         end else begin
            M_DR = oldWord;
         end
      end
   end

   // RAM: asynchronous clear on low reset, otherwise commit legal stores.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (writeEn) begin
         mem[wordIdx] <= mergedWord;
      end
   end

`ifdef DM_WRITE_LOG_EN
   // Trace each committed store with its PC, word address and merged word.
   always_ff @(posedge clk) begin
      if (reset && writeEn) begin
         $display("%d@%h: *%h <= %h", $time, M_PC, {M_AO[31:2], 2'b00}, mergedWord);
      end
   end
`else
   logic unusedPc;
   assign unusedPc = ^M_PC;
`endif

endmodule

// File: tb/tb_m_stage_dm.sv
// tb_m_stage_dm: directed bench for m_stage_dm, expected values hand-computed.
module tb_m_stage_dm;

   logic        clk;
   logic        reset;
   logic [31:0] M_PC;
   logic [31:0] M_AO;
   logic [31:0] M_WD;
   logic        M_MemWrite;
   logic        M_MemRead;
   logic [1:0]  M_MemSize;
   logic        M_LoadSigned;
   logic [31:0] M_DR;
   logic        M_AdEL;
   logic        M_AdES;

   int errors = 0;
   int checks = 0;

   localparam logic [1:0] SZ_W = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_B = 2'b10;
   localparam logic [1:0] SZ_R = 2'b11;

   m_stage_dm dut (
      .clk          (clk),
      .reset        (reset),
      .M_PC         (M_PC),
      .M_AO         (M_AO),
      .M_WD         (M_WD),
      .M_MemWrite   (M_MemWrite),
      .M_MemRead    (M_MemRead),
      .M_MemSize    (M_MemSize),
      .M_LoadSigned (M_LoadSigned),
      .M_DR         (M_DR),
      .M_AdEL       (M_AdEL),
      .M_AdES       (M_AdES)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one access at the falling edge; the next rising edge commits it.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      M_PC         = M_PC + 32'd4;
      M_MemRead    = rd;
      M_MemWrite   = wr;
      M_MemSize    = size;
      M_LoadSigned = sgn;
      M_AO         = addr;
      M_WD         = wd;
   endtask

   // Sample outputs 1 time unit after the drive, well clear of the rising edge.
   task automatic checkOutput(input string tag, input logic [31:0] expDr,
                              input logic expAdEL, input logic expAdES);
      #1;
      checks++;
      assert (M_DR === expDr) else begin
         errors++;
         $error("[TB] FAIL %s M_DR got=%h want=%h", tag, M_DR, expDr);
      end
      checks++;
      assert (M_AdEL === expAdEL) else begin
         errors++;
         $error("[TB] FAIL %s M_AdEL got=%b want=%b", tag, M_AdEL, expAdEL);
      end
      checks++;
      assert (M_AdES === expAdES) else begin
         errors++;
         $error("[TB] FAIL %s M_AdES got=%b want=%b", tag, M_AdES, expAdES);
      end
   endtask

   // Directed sequence following the memory-stage scenarios.
   initial begin
      reset        = 1'b0;
      M_PC         = 32'h0040_0000;
      M_AO         = '0;
      M_WD         = '0;
      M_MemWrite   = 1'b0;
      M_MemRead    = 1'b0;
      M_MemSize    = SZ_W;
      M_LoadSigned = 1'b0;

      // Reset held low over a few edges; outputs idle.
      repeat (2) @(posedge clk);
      checkOutput("reset_idle", 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      applyStimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_0010, 32'h0);
      checkOutput("lw_after_reset", 32'h0, 1'b0, 1'b0);

      applyStimulus(1'b0, 1'b1, SZ_W, 1'b0, 32'h0000_0040, 32'h1234_5678);
      checkOutput("sw_40", 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_0040, 32'h0);
      checkOutput("lw_40", 32'h1234_5678, 1'b0, 1'b0);

      applyStimulus(1'b0, 1'b1, SZ_B, 1'b0, 32'h0000_0041, 32'h0000_00AB);
      checkOutput("sb_41", 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_B, 1'b1, 32'h0000_0041, 32'h0);
      checkOutput("lb_41", 32'hFFFF_FFAB, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_B, 1'b0, 32'h0000_0041, 32'h0);
      checkOutput("lbu_41", 32'h0000_00AB, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_W, 1'b1, 32'h0000_0040, 32'h0);
      checkOutput("lw_40_after_sb", 32'h1234_AB78, 1'b0, 1'b0);

      applyStimulus(1'b0, 1'b1, SZ_H, 1'b0, 32'h0000_0042, 32'hFFFF_8001);
      checkOutput("sh_42", 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_H, 1'b1, 32'h0000_0042, 32'h0);
      checkOutput("lh_42", 32'hFFFF_8001, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_H, 1'b0, 32'h0000_0042, 32'h0);
      checkOutput("lhu_42", 32'h0000_8001, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_H, 1'b1, 32'h0000_0040, 32'h0);
      checkOutput("lh_40_low", 32'hFFFF_AB78, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_B, 1'b0, 32'h0000_0043, 32'h0);
      checkOutput("lbu_43", 32'h0000_0080, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_0040, 32'h0);
      checkOutput("lw_40_after_sh", 32'h8001_AB78, 1'b0, 1'b0);

      // Error cases: suppressed stores and blocked loads.
      applyStimulus(1'b0, 1'b1, SZ_W, 1'b0, 32'h0000_0046, 32'hDEAD_BEEF);
      checkOutput("sw_46_misaligned", 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_0044, 32'h0);
      checkOutput("lw_44_untouched", 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, SZ_W, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF);
      checkOutput("sw_4000_range", 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_0000, 32'h0);
      checkOutput("lw_0_untouched", 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_H, 1'b1, 32'h0000_0043, 32'h0);
      checkOutput("lh_43_misaligned", 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_4000, 32'h0);
      checkOutput("lw_4000_range", 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_3FFC, 32'h0);
      checkOutput("lw_3ffc_last", 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, SZ_W, 1'b0, 32'h0000_0040, 32'h0);
      checkOutput("bubble_40", 32'h0, 1'b0, 1'b0);

      // Simultaneous read and write: read sees pre-edge contents.
      applyStimulus(1'b1, 1'b1, SZ_W, 1'b0, 32'h0000_0040, 32'hCAFE_F00D);
      checkOutput("rw_same_cycle", 32'h8001_AB78, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_R, 1'b1, 32'h0000_0040, 32'h0);
      checkOutput("lw_reserved_size", 32'hCAFE_F00D, 1'b0, 1'b0);

      // Reset held low across the edge of a store discards that store.
      applyStimulus(1'b0, 1'b1, SZ_W, 1'b0, 32'h0000_0080, 32'hFFFF_FFFF);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_0080, 32'h0);
      checkOutput("lw_80_after_reset", 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_0040, 32'h0);
      checkOutput("lw_40_cleared", 32'h0, 1'b0, 1'b0);

      // Writes resume after release.
      applyStimulus(1'b0, 1'b1, SZ_W, 1'b0, 32'h0000_0080, 32'h5A5A_5A5A);
      checkOutput("sw_80_resume", 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_0080, 32'h0);
      checkOutput("lw_80_resume", 32'h5A5A_5A5A, 1'b0, 1'b0);

      applyStimulus(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
